kbd_matrix_scan: RTL and testbench

KBD_MATRIX_SCAN -- requirements
Module: kbd_matrix_scan

---
 rtl/kbd_matrix_scan.sv | 181 ++++++++++++++++++
 tb/tb_kbd_matrix_scan.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/kbd_matrix_scan.sv
// Row-scanned key matrix with per-key debounce and a valid/ready event stream.
// Optional ghost rejection is compiled in with KBD_GHOST_DETECT_EN.
module kbd_matrix_scan #(
  parameter int ROWS     = 6,
  parameter int COLS     = 21,
  parameter int SETTLE   = 4,
  parameter int DEBOUNCE = 3,
  localparam int CODE_W  = $clog2(ROWS * COLS)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enabled,
  input  logic [COLS-1:0]        COL,
  output logic [ROWS-1:0]        ROW,
  output logic [ROWS*COLS-1:0]   key_state,
  output logic                   ev_valid,
  input  logic                   ev_ready,
  output logic [CODE_W-1:0]      ev_code,
  output logic                   ev_press,
  output logic                   scan_done,
  output logic                   ghost,
  output logic [1:0]             dbg_state
);

  localparam int KEYS = ROWS * COLS;
  localparam int RW   = $clog2(ROWS);
  localparam int DW   = $clog2(SETTLE);
  localparam int CW   = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DRAIN} state_t;

  // Event handshake: an event transfers on a rising edge where ev_valid && ev_ready;
  // ev_valid/ev_code/ev_press are registers and hold while ev_valid && !ev_ready.
  state_t              state;
  logic [RW-1:0]       row;
  logic [DW-1:0]       dwell;
  logic [CW-1:0]       cnt [KEYS];
  logic [COLS-1:0]     pending;
  logic [COLS-1:0]     col_s1, col_s2;

  logic [CODE_W-1:0]   row_base, idx, low_c, ev_code_nx;
  logic [COLS-1:0]     ks_row, ks_row_nx, ks_src, sample_pend, pend_src;
  logic [CW-1:0]       cnt_row_nx [COLS];
  logic                ev_press_nx, ghost_hit;

  assign dbg_state = state;

  function automatic logic [ROWS-1:0] row_drive(input logic [RW-1:0] r);
    return ~(ROWS'(1) << r);
  endfunction

`ifdef KBD_GHOST_DETECT_EN
  logic [COLS-1:0] other_cols;
  // A row showing 2+ closures that share a column with a held key elsewhere may be phantom.
  always_comb begin
    other_cols = '0;
    for (int r = 0; r < ROWS; r++)
      if (RW'(r) != row) other_cols = other_cols | key_state[r*COLS +: COLS];
    ghost_hit = (state == S_SAMPLE) && ($countones(col_s2) > 1) && (|(col_s2 & other_cols));
  end
`else
  assign ghost_hit = 1'b0;
`endif

  always_comb begin
    row_base    = CODE_W'(row) * CODE_W'(COLS);
    ks_row      = key_state[row_base +: COLS];
    ks_row_nx   = ks_row;
    sample_pend = '0;
    idx         = '0;
    for (int c = 0; c < COLS; c++) begin
      idx           = row_base + CODE_W'(c);
      cnt_row_nx[c] = cnt[idx];
      if (!ghost_hit) begin
        if (col_s2[c] == ks_row[c]) begin
          cnt_row_nx[c] = '0;
        end else if (cnt[idx] == CW'(DEBOUNCE - 1)) begin
          cnt_row_nx[c]  = '0;
          ks_row_nx[c]   = ~ks_row[c];
          sample_pend[c] = 1'b1;
        end else begin
          cnt_row_nx[c] = cnt[idx] + CW'(1);
        end
      end
    end
    if (state == S_SAMPLE)          pend_src = sample_pend;
    else if (ev_valid && ev_ready)  pend_src = pending & (pending - COLS'(1));
    else                            pend_src = pending;
    ks_src      = (state == S_SAMPLE) ? ks_row_nx : ks_row;
    low_c       = '0;
    ev_press_nx = 1'b0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (pend_src[c]) begin
        low_c       = CODE_W'(c);
        ev_press_nx = ks_src[c];
      end
    end
    ev_code_nx = row_base + low_c;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      row       <= '0;
      dwell     <= '0;
      pending   <= '0;
      key_state <= '0;
      ev_valid  <= 1'b0;
      ev_code   <= '0;
      ev_press  <= 1'b0;
      scan_done <= 1'b0;
      ghost     <= 1'b0;
      ROW       <= '1;
      col_s1    <= '0;
      col_s2    <= '0;
      for (int k = 0; k < KEYS; k++) cnt[k] <= '0;
    end else begin
      col_s1    <= COL;
      col_s2    <= col_s1;
      scan_done <= 1'b0;
      ghost     <= 1'b0;
      case (state)
        S_IDLE: begin
          ROW <= '1;
          if (enabled) begin
            state <= S_SETTLE;
            dwell <= '0;
            ROW   <= row_drive(row);
          end
        end
        S_SETTLE: begin
          if (!enabled) begin
            state <= S_IDLE;
            dwell <= '0;
            ROW   <= '1;
          end else if (dwell == DW'(SETTLE - 1)) begin
            state <= S_SAMPLE;
          end else begin
            dwell <= dwell + DW'(1);
          end
        end
        S_SAMPLE: begin
          state                        <= S_DRAIN;
          ghost                        <= ghost_hit;
          key_state[row_base +: COLS]  <= ks_row_nx;
          for (int c = 0; c < COLS; c++) cnt[row_base + CODE_W'(c)] <= cnt_row_nx[c];
          pending  <= pend_src;
          ev_valid <= |pend_src;
          if (|pend_src) begin
            ev_code  <= ev_code_nx;
            ev_press <= ev_press_nx;
          end
        end
        S_DRAIN: begin
          if (pending == '0) begin
            // Row is only released once every event of this row has been taken.
            row       <= (row == RW'(ROWS - 1)) ? '0 : row + RW'(1);
            scan_done <= (row == RW'(ROWS - 1));
            dwell     <= '0;
            if (enabled) begin
              state <= S_SETTLE;
              ROW   <= row_drive((row == RW'(ROWS - 1)) ? '0 : row + RW'(1));
            end else begin
              state <= S_IDLE;
              ROW   <= '1;
            end
          end else begin
            pending  <= pend_src;
            ev_valid <= |pend_src;
            if (|pend_src) begin
              ev_code  <= ev_code_nx;
              ev_press <= ev_press_nx;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kbd_matrix_scan.sv
// Directed bench for kbd_matrix_scan: a key-matrix model drives COL from ROW,
// a negedge monitor logs transfers, and each step is checked against hand values.
module tb_kbd_matrix_scan;

  localparam int ROWS = 6;
  localparam int COLS = 21;
  localparam int CW   = 7;

  logic                 clock = 1'b0;
  logic                 reset, enabled, ev_ready;
  logic [COLS-1:0]      COL;
  logic [ROWS-1:0]      ROW;
  logic [ROWS*COLS-1:0] key_state;
  logic                 ev_valid, ev_press, scan_done, ghost;
  logic [CW-1:0]        ev_code;
  logic [1:0]           dbg_state;

  kbd_matrix_scan dut (
    .clock(clock), .reset(reset), .enabled(enabled), .COL(COL), .ROW(ROW),
    .key_state(key_state), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_code(ev_code), .ev_press(ev_press), .scan_done(scan_done),
    .ghost(ghost), .dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  logic pressed [ROWS][COLS];

  always_comb begin
    COL = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (!ROW[r] && pressed[r][c]) COL[c] = 1'b1;
  end

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int ghost_cnt   = 0;
  int done_cnt    = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int         got_t[$];

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (!reset) begin
      if (ev_valid && ev_ready) begin
        got_q.push_back({ev_press, ev_code});
        got_t.push_back(cyc);
      end
      if (ghost)     ghost_cnt++;
      if (scan_done) done_cnt++;
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic clear_keys();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        pressed[r][c] = 1'b0;
  endtask

  task automatic wait_scan_done(input int budget, output int waited);
    waited = 0;
    do begin
      tick(1);
      waited++;
    end while (!scan_done && waited < budget);
    check("wait_scan_done", scan_done, 1'b1);
  endtask

  task automatic wait_ev_valid(input int budget);
    int n = 0;
    while (!ev_valid && n < budget) begin
      tick(1);
      n++;
    end
    check("wait_ev_valid", ev_valid, 1'b1);
  endtask

  task automatic check_events(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0)
      check(tag, got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
    got_t.delete();
  endtask

  initial begin
    int w, snap;
    logic [127:0] ks_exp;

    reset = 1'b1; enabled = 1'b0; ev_ready = 1'b1;
    clear_keys();
    tick(3);
    check("rst_row", ROW, 6'h3f);
    check("rst_key_state", key_state, '0);
    check("rst_ev_valid", ev_valid, 1'b0);
    check("rst_ev_code", ev_code, '0);
    check("rst_ev_press", ev_press, 1'b0);
    check("rst_scan_done", scan_done, 1'b0);
    check("rst_ghost", ghost, 1'b0);
    check("rst_state", dbg_state, 2'd0);

    reset = 1'b0;
    tick(2);
    check("idle_row", ROW, 6'h3f);
    enabled = 1'b1;
    tick(1);
    check("first_row0", ROW, 6'h3e);
    check("first_settle", dbg_state, 2'd1);
    wait_scan_done(100, w);
    check("first_scan_len", w, 36);
    wait_scan_done(100, w);
    check("scan_period", w, 36);

    // Single key (2,5) held long enough to debounce, then released.
    pressed[2][5] = 1'b1;
    tick(144);
    exp_q.push_back({1'b1, 7'd47});
    check_events("press47");
    ks_exp = '0; ks_exp[47] = 1'b1;
    check("press47_state", key_state, ks_exp);
    pressed[2][5] = 1'b0;
    tick(144);
    exp_q.push_back({1'b0, 7'd47});
    check_events("release47");
    check("release47_state", key_state, '0);

    // Two samples only: the counter must not reach the flip threshold.
    wait_scan_done(40, w);
    pressed[2][5] = 1'b1;
    tick(72);
    pressed[2][5] = 1'b0;
    tick(72);
    check_events("bounce47");
    check("bounce47_state", key_state, '0);

    // Three keys on row 1 under backpressure.
    ev_ready = 1'b0;
    pressed[1][0] = 1'b1; pressed[1][4] = 1'b1; pressed[1][7] = 1'b1;
    wait_ev_valid(200);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("stall_row", ROW, 6'h3d);
      check("stall_code", ev_code, 7'd21);
      check("stall_valid", ev_valid, 1'b1);
    end
    ev_ready = 1'b1;
    tick(4);
    check("drain_next_row", ROW, 6'h3b);
    check("drain_valid_low", ev_valid, 1'b0);
    check("burst_count", got_t.size(), 3);
    if (got_t.size() == 3) begin
      check("burst_gap0", got_t[1] - got_t[0], 1);
      check("burst_gap1", got_t[2] - got_t[1], 1);
    end
    exp_q.push_back({1'b1, 7'd21});
    exp_q.push_back({1'b1, 7'd25});
    exp_q.push_back({1'b1, 7'd28});
    check_events("burst");
    clear_keys();
    tick(144);
    exp_q.push_back({1'b0, 7'd21});
    exp_q.push_back({1'b0, 7'd25});
    exp_q.push_back({1'b0, 7'd28});
    check_events("burst_rel");

    // Disable during row 3 SETTLE, then resume on the same row.
    w = 0;
    while (!(dbg_state == 2'd1 && ROW == 6'h37) && w < 100) begin
      tick(1);
      w++;
    end
    check("find_row3", ROW, 6'h37);
    snap = done_cnt;
    enabled = 1'b0;
    tick(1);
    check("dis_row", ROW, 6'h3f);
    check("dis_state", dbg_state, 2'd0);
    tick(20);
    check("dis_row_hold", ROW, 6'h3f);
    check("dis_no_scan_done", done_cnt - snap, 0);
    enabled = 1'b1;
    tick(1);
    check("reen_row3", ROW, 6'h37);
    check("reen_settle", dbg_state, 2'd1);
    check_events("dis_events");

    // Ghost scenario: three real keys, then the phantom (1,1).
    wait_scan_done(50, w);
    pressed[0][0] = 1'b1; pressed[0][1] = 1'b1; pressed[1][0] = 1'b1;
    tick(144);
    exp_q.push_back({1'b1, 7'd0});
    exp_q.push_back({1'b1, 7'd1});
    exp_q.push_back({1'b1, 7'd21});
    check_events("ghost_setup");
    snap = ghost_cnt;
    pressed[1][1] = 1'b1;
    tick(144);
    ks_exp = '0; ks_exp[0] = 1'b1; ks_exp[1] = 1'b1; ks_exp[21] = 1'b1;
`ifdef KBD_GHOST_DETECT_EN
    check("ghost_pulses", (ghost_cnt - snap) >= 3, 1'b1);
`else
    check("ghost_pulses", ghost_cnt - snap, 0);
    exp_q.push_back({1'b1, 7'd22});
    ks_exp[22] = 1'b1;
`endif
    check_events("ghost_phantom");
    check("ghost_state", key_state, ks_exp);

    // Reset while an event is stalled.
    ev_ready = 1'b0;
    pressed[4][3] = 1'b1;
    wait_ev_valid(200);
    check("stalled_code", ev_code, 7'd87);
    reset = 1'b1;
    clear_keys();
    tick(1);
    check("mid_rst_valid", ev_valid, 1'b0);
    check("mid_rst_state", key_state, '0);
    check("mid_rst_row", ROW, 6'h3f);
    check("mid_rst_fsm", dbg_state, 2'd0);
    reset = 1'b0;
    tick(1);
    check("restart_row0", ROW, 6'h3e);
    ev_ready = 1'b1;
    tick(40);
    check_events("post_rst");
    check("post_rst_state", key_state, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
